mem2wb_pipe_reg: RTL and testbench
==================================

Name: mem2wb_pipe_reg

Overview:
Parametrised MEM/WB pipeline register for the multi-issue core. It is the successor to the single-lane MEM-to-WB latch.
- Carries LANES register-write bundles per cycle.
- Valid/ready handshake with backpressure from WB.
- Synchronous flush.
- Write-enable sanitising: $zero writes and same-bundle address collisions are squashed.
- Sits between the MEM stage and the regfile write port / bypass network.

Parameters:
LANES, 2, number of parallel write lanes per bundle (1..4)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous, active-low reset
flush_i  input  1  synchronous flush: drops held and incoming bundles
mem_valid_i  input  1  MEM bundle valid
mem_ready_o  output  1  stage can accept a bundle this cycle
mem_wd_i  input  LANES*ADDR_W  per-lane destination address, lane 0 in LSBs
mem_wreg_i  input  LANES  per-lane write enable
mem_wdata_i  input  LANES*DATA_W  per-lane write data
wb_valid_o  output  1  WB bundle valid
wb_ready_i  input  1  WB consumes bundle
wb_wd_o  output  LANES*ADDR_W  registered addresses
wb_wreg_o  output  LANES  registered, sanitised write enables
wb_wdata_o  output  LANES*DATA_W  registered data

Behaviour:
- Reset (rst_i low, asynchronous):
  - wb_valid_o=0, wb_wd_o=0 (NOP address), wb_wreg_o=0, wb_wdata_o=0.
  - Skid state cleared.
  - mem_ready_o=1 immediately after release.
- Accept: accept = mem_valid_i & mem_ready_o & ~flush_i.
- Base mode (no skid):
  - mem_ready_o = ~wb_valid_o | wb_ready_i (combinational).
  - On accept, the output registers load the bundle next edge and wb_valid_o=1. Latency is 1 cycle.
  - If wb_valid_o & wb_ready_i & ~accept, then wb_valid_o clears next edge; payload is don't-care but implemented as held.
  - If wb_valid_o & ~wb_ready_i, all outputs hold stable (no change while stalled).
- Sanitising (applied before registering):
  - Lane k wreg forced 0 if mem_wd_i[k]==0.
  - Lane k wreg forced 0 if any higher lane j>k has wreg=1 with the same address. The youngest lane wins.
  - Address and data are registered unmodified.
- Flush:
  - Takes priority over everything. Next edge: wb_valid_o=0, wb_wreg_o=0, skid cleared.
  - wb_wd_o/wb_wdata_o are zeroed.
  - Incoming bundle in the flush cycle is dropped, even if mem_ready_o=1.
- Bundle with mem_valid_i=1 and all wreg 0: still a valid transfer (wb_valid_o=1, wb_wreg_o=0). Required for instruction retirement accounting.
- No bundle is ever duplicated or lost except by flush.

Optional Feature:
MEM2WB_SKID_EN
- Defined: adds a one-entry skid buffer so mem_ready_o is a register output.
  - mem_ready_o = ~skid_valid.
  - If an accept occurs while wb_valid_o & ~wb_ready_i, the bundle goes into skid.
  - When WB consumes, skid moves to the outputs next edge. Skid has priority over the new input; mem_ready_o stays low that cycle.
  - Throughput 1/cycle. Latency 1 cycle when skid is empty.
  - Flush clears both entries.
- Undefined: base mode above, zero skid logic.

Decomposition:
- Shared package mem2wb_pkg: NOP_REG_ADDR (0), ZERO_WORD, and a packed lane struct typedef {addr, wreg, data} parametrised through the module.
- One sub-module: mem2wb_wreg_sanitise (combinational collision/$zero mask). It is reused by the ID-stage bypass check.

Test Plan:
- Reset mid-transfer: hold wb_ready_i=0 with a valid bundle, pull rst_i low asynchronously -> wb_valid_o=0 and wb_wreg_o=0 before the next edge; mem_ready_o=1 after release.
- Streaming: wb_ready_i=1, 8 back-to-back bundles (lane0 addr 1..8, data 0x100+n) -> identical sequence on WB, 1-cycle latency, no bubbles.
- Backpressure: wb_ready_i=0 for 3 cycles after bundle A -> outputs hold A, mem_ready_o=0 (base) -> B appears the cycle after wb_ready_i=1.
- Sanitise: lane0 {addr 7, wreg 1}, lane1 {addr 7, wreg 1} -> wb_wreg_o=2'b10. Lane0 addr 0 wreg 1 -> wb_wreg_o[0]=0.
- Flush with simultaneous mem_valid_i=1 and a held bundle -> next edge wb_valid_o=0, wb_wreg_o=0, outputs zero; the incoming bundle never appears.
- MEM2WB_SKID_EN: wb_ready_i low while accepting 2 bundles -> second lands in skid, mem_ready_o=0. Release -> both emerge in order on consecutive cycles.

Source files
------------

// File: rtl/mem2wb_pkg.sv
// Shared constants for the MEM/WB pipeline register and its write-enable sanitiser.
// Register address 0 is the hardwired $zero; writes to it never reach the regfile.
package mem2wb_pkg;

    localparam int unsigned NOP_REG_ADDR = 0;
    localparam logic [63:0] ZERO_WORD    = 64'h0;

endpackage

// File: rtl/mem2wb_wreg_sanitise.sv
// Combinational write-enable mask: squashes $zero writes and same-bundle collisions,
// keeping only the youngest (highest-numbered) lane for any repeated destination.
module mem2wb_wreg_sanitise
    import mem2wb_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int ADDR_W = 5
) (
    input  logic [LANES*ADDR_W-1:0] wd,
    input  logic [LANES-1:0]        wreg,
    output logic [LANES-1:0]        wreg_clean
);

    // NOTE: full default assignment before the loops, so no path leaves a bit unassigned (no latch).
    always_comb begin
        wreg_clean = wreg;
        for (int k = 0; k < LANES; k++) begin
            if (wd[k*ADDR_W +: ADDR_W] == ADDR_W'(NOP_REG_ADDR)) begin
                wreg_clean[k] = 1'b0;
            end
            for (int j = k + 1; j < LANES; j++) begin
                if (wreg[j] && (wd[j*ADDR_W +: ADDR_W] == wd[k*ADDR_W +: ADDR_W])) begin
                    wreg_clean[k] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/mem2wb_pipe_reg.sv
// MEM/WB pipeline register for LANES parallel write bundles with valid/ready and flush.
// Optional MEM2WB_SKID_EN adds a one-entry skid so mem_ready_o comes straight from a flop.
module mem2wb_pipe_reg
    import mem2wb_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    mem_valid_i,
    output logic                    mem_ready_o,
    input  logic [LANES*ADDR_W-1:0] mem_wd_i,
    input  logic [LANES-1:0]        mem_wreg_i,
    input  logic [LANES*DATA_W-1:0] mem_wdata_i,
    output logic                    wb_valid_o,
    input  logic                    wb_ready_i,
    output logic [LANES*ADDR_W-1:0] wb_wd_o,
    output logic [LANES-1:0]        wb_wreg_o,
    output logic [LANES*DATA_W-1:0] wb_wdata_o
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wreg;
        logic [DATA_W-1:0] data;
    } lane_t;

    localparam lane_t NOP_LANE = '{
        addr: ADDR_W'(NOP_REG_ADDR),
        wreg: 1'b0,
        data: DATA_W'(ZERO_WORD)
    };

    lane_t [LANES-1:0] in_lanes;
    lane_t [LANES-1:0] out_q;
    logic  [LANES-1:0] wreg_clean;
    logic              accept;

    mem2wb_wreg_sanitise #(
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) u_sanitise (
        .wd         (mem_wd_i),
        .wreg       (mem_wreg_i),
        .wreg_clean (wreg_clean)
    );

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign in_lanes[k] = '{
            addr: mem_wd_i[k*ADDR_W +: ADDR_W],
            wreg: wreg_clean[k],
            data: mem_wdata_i[k*DATA_W +: DATA_W]
        };
        assign wb_wd_o[k*ADDR_W +: ADDR_W]    = out_q[k].addr;
        assign wb_wreg_o[k]                   = out_q[k].wreg;
        assign wb_wdata_o[k*DATA_W +: DATA_W] = out_q[k].data;
    end

`ifdef MEM2WB_SKID_EN
    lane_t [LANES-1:0] skid_q;
    logic              skid_valid_q;
    logic              out_free;

    assign out_free    = ~wb_valid_o | wb_ready_i;
    assign mem_ready_o = ~skid_valid_q;
    assign accept      = mem_valid_i & mem_ready_o & ~flush_i;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_valid_o   <= 1'b0;
            skid_valid_q <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                out_q[k]  <= NOP_LANE;
                skid_q[k] <= NOP_LANE;
            end
        end else if (flush_i) begin
            wb_valid_o   <= 1'b0;
            skid_valid_q <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                out_q[k]  <= NOP_LANE;
                skid_q[k] <= NOP_LANE;
            end
        end else if (out_free) begin
            // A parked bundle is older than anything on the input, so it drains first.
            if (skid_valid_q) begin
                out_q        <= skid_q;
                skid_valid_q <= 1'b0;
                wb_valid_o   <= 1'b1;
            end else if (accept) begin
                out_q      <= in_lanes;
                wb_valid_o <= 1'b1;
            end else begin
                wb_valid_o <= 1'b0;
            end
        end else if (accept) begin
            skid_q       <= in_lanes;
            skid_valid_q <= 1'b1;
        end
    end
`else
    assign mem_ready_o = ~wb_valid_o | wb_ready_i;
    assign accept      = mem_valid_i & mem_ready_o & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_valid_o <= 1'b0;
            for (int k = 0; k < LANES; k++) out_q[k] <= NOP_LANE;
        end else if (flush_i) begin
            wb_valid_o <= 1'b0;
            for (int k = 0; k < LANES; k++) out_q[k] <= NOP_LANE;
        end else if (accept) begin
            out_q      <= in_lanes;
            wb_valid_o <= 1'b1;
        end else if (wb_ready_i) begin
            // Payload is left as-is once consumed; only the valid bit drops.
            wb_valid_o <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mem2wb_pipe_reg.sv
// Self-checking bench for mem2wb_pipe_reg: sanitise vector table, directed corner sequences,
// and randomized traffic against a queue-based reference (capacity 1 base, 2 with MEM2WB_SKID_EN).
module tb_mem2wb_pipe_reg;

    localparam int LANES  = 2;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int AW     = LANES * ADDR_W;
    localparam int DW     = LANES * DATA_W;
`ifdef MEM2WB_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk_i       = 1'b0;
    logic          rst_i       = 1'b0;
    logic          flush_i     = 1'b0;
    logic          mem_valid_i = 1'b0;
    logic          wb_ready_i  = 1'b0;
    logic [AW-1:0] mem_wd_i    = '0;
    logic [LANES-1:0] mem_wreg_i = '0;
    logic [DW-1:0] mem_wdata_i = '0;
    logic          mem_ready_o;
    logic          wb_valid_o;
    logic [AW-1:0] wb_wd_o;
    logic [LANES-1:0] wb_wreg_o;
    logic [DW-1:0] wb_wdata_o;

    always #5 clk_i = ~clk_i;

    mem2wb_pipe_reg #(
        .LANES  (LANES),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .mem_valid_i (mem_valid_i),
        .mem_ready_o (mem_ready_o),
        .mem_wd_i    (mem_wd_i),
        .mem_wreg_i  (mem_wreg_i),
        .mem_wdata_i (mem_wdata_i),
        .wb_valid_o  (wb_valid_o),
        .wb_ready_i  (wb_ready_i),
        .wb_wd_o     (wb_wd_o),
        .wb_wreg_o   (wb_wreg_o),
        .wb_wdata_o  (wb_wdata_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: the stage behaves as a small FIFO whose head is what WB sees.
    typedef struct {
        logic [AW-1:0]    wd;
        logic [LANES-1:0] wreg;
        logic [DW-1:0]    wdata;
    } bundle_t;

    bundle_t q[$];
    bit      m_zero = 1'b1;

    // Walk lanes youngest-first; each nonzero address is claimed by the first enabled lane seen.
    function automatic logic [LANES-1:0] ref_wreg(input logic [AW-1:0] wd, input logic [LANES-1:0] wreg);
        bit claimed [1 << ADDR_W];
        logic [LANES-1:0] r;
        int unsigned a;
        r = '0;
        foreach (claimed[i]) claimed[i] = 1'b0;
        for (int k = LANES - 1; k >= 0; k--) begin
            a = int'(wd[k*ADDR_W +: ADDR_W]);
            if (wreg[k]) begin
                if (a != 0 && !claimed[a]) r[k] = 1'b1;
                claimed[a] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic bit model_ready(input bit r);
        return SKID ? (q.size() < 2) : (q.size() == 0 || r);
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, " valid"}, wb_valid_o, q.size() > 0);
        if (q.size() > 0) begin
            check({tag, " wd"},    wb_wd_o,    q[0].wd);
            check({tag, " wreg"},  wb_wreg_o,  q[0].wreg);
            check({tag, " wdata"}, wb_wdata_o, q[0].wdata);
        end else if (m_zero) begin
            check({tag, " wd zero"},    wb_wd_o,    0);
            check({tag, " wreg zero"},  wb_wreg_o,  0);
            check({tag, " wdata zero"}, wb_wdata_o, 0);
        end
    endtask

    // One clock: drive at negedge, check ready, advance model, check outputs after the edge.
    task automatic cycle(input string tag, input bit v, input bit r, input bit f,
                         input logic [AW-1:0] wd, input logic [LANES-1:0] wreg, input logic [DW-1:0] wdata);
        bit rdy;
        bundle_t b;
        mem_valid_i = v;
        wb_ready_i  = r;
        flush_i     = f;
        mem_wd_i    = wd;
        mem_wreg_i  = wreg;
        mem_wdata_i = wdata;
        #1;
        rdy = model_ready(r);
        check({tag, " ready"}, mem_ready_o, rdy);
        if (f) begin
            q.delete();
            m_zero = 1'b1;
        end else begin
            if (q.size() > 0 && r) void'(q.pop_front());
            if (v && rdy) begin
                b.wd    = wd;
                b.wreg  = ref_wreg(wd, wreg);
                b.wdata = wdata;
                q.push_back(b);
                m_zero = 1'b0;
            end
        end
        @(posedge clk_i);
        #1;
        check_outputs(tag);
        @(negedge clk_i);
    endtask

    typedef struct {
        logic [AW-1:0]    wd;
        logic [LANES-1:0] wreg;
        logic [LANES-1:0] exp_wreg;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{{5'd7, 5'd7}, 2'b11, 2'b10};
        vecs[1] = '{{5'd4, 5'd0}, 2'b01, 2'b00};
        vecs[2] = '{{5'd5, 5'd3}, 2'b11, 2'b11};
        vecs[3] = '{{5'd0, 5'd0}, 2'b11, 2'b00};
        vecs[4] = '{{5'd7, 5'd7}, 2'b01, 2'b01};
        vecs[5] = '{{5'd9, 5'd9}, 2'b00, 2'b00};
        vecs[6] = '{{5'd0, 5'd4}, 2'b11, 2'b01};

        // Reset state
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("reset valid", wb_valid_o, 0);
        check("reset wreg",  wb_wreg_o,  0);
        check("reset wd",    wb_wd_o,    0);
        check("reset wdata", wb_wdata_o, 0);
        check("reset ready", mem_ready_o, 1);
        @(negedge clk_i);

        // Sanitise table
        for (int i = 0; i < 7; i++) begin
            cycle("san", 1'b1, 1'b1, 1'b0, vecs[i].wd, vecs[i].wreg, {$urandom, $urandom});
            check($sformatf("san%0d valid", i), wb_valid_o, 1);
            check($sformatf("san%0d wreg", i),  wb_wreg_o,  vecs[i].exp_wreg);
        end
        cycle("san_drain", 1'b0, 1'b1, 1'b0, '0, '0, '0);

        // Streaming: 8 back-to-back bundles, no bubbles
        for (int n = 1; n <= 8; n++) begin
            cycle("stream", 1'b1, 1'b1, 1'b0, {5'd0, 5'(n)}, 2'b01, {32'h0, 32'h100 + 32'(n)});
            check("stream lane0 addr", wb_wd_o[ADDR_W-1:0], n);
            check("stream lane0 data", wb_wdata_o[DATA_W-1:0], 32'h100 + n);
        end
        cycle("stream_drain", 1'b0, 1'b1, 1'b0, '0, '0, '0);

        // Backpressure: A held for 3 stalled cycles, B follows once WB is ready
        cycle("bp_a", 1'b1, 1'b0, 1'b0, {5'd2, 5'd1}, 2'b11, 64'h0000_00bb_0000_00aa);
        for (int i = 0; i < 3; i++) begin
            cycle("bp_stall", 1'b1, 1'b0, 1'b0, {5'd4, 5'd3}, 2'b11, 64'h0000_0bbb_0000_0aaa);
            check("bp hold addr", wb_wd_o, {5'd2, 5'd1});
        end
        cycle("bp_go", 1'b1, 1'b1, 1'b0, {5'd4, 5'd3}, 2'b11, 64'h0000_0bbb_0000_0aaa);
        check("bp B addr", wb_wd_o, {5'd4, 5'd3});
        cycle("bp_drain", 1'b0, 1'b1, 1'b0, '0, '0, '0);
        check("bp drained", wb_valid_o, 0);

        // Flush with a held bundle and a simultaneous incoming one
        cycle("fl_a", 1'b1, 1'b0, 1'b0, {5'd6, 5'd5}, 2'b11, 64'h1111_2222_3333_4444);
        cycle("fl", 1'b1, 1'b0, 1'b1, {5'd8, 5'd7}, 2'b11, 64'h5555_6666_7777_8888);
        check("flush valid", wb_valid_o, 0);
        check("flush wdata", wb_wdata_o, 0);
        cycle("fl_idle", 1'b0, 1'b1, 1'b0, '0, '0, '0);
        cycle("fl_open", 1'b1, 1'b1, 1'b1, {5'd9, 5'd9}, 2'b11, 64'h9);
        cycle("fl_idle2", 1'b0, 1'b1, 1'b0, '0, '0, '0);

`ifdef MEM2WB_SKID_EN
        // Two accepts under stall: second parks in skid, then both drain in order
        cycle("sk_a", 1'b1, 1'b0, 1'b0, {5'd0, 5'd11}, 2'b01, 64'ha);
        cycle("sk_b", 1'b1, 1'b0, 1'b0, {5'd0, 5'd12}, 2'b01, 64'hb);
        check("skid full ready", mem_ready_o, 0);
        check("skid A on out", wb_wd_o, {5'd0, 5'd11});
        cycle("sk_rel", 1'b0, 1'b1, 1'b0, '0, '0, '0);
        check("skid B on out", wb_wd_o, {5'd0, 5'd12});
        check("skid B valid", wb_valid_o, 1);
        cycle("sk_rel2", 1'b0, 1'b1, 1'b0, '0, '0, '0);
        check("skid empty", wb_valid_o, 0);
`endif

        // Reset mid-transfer: asynchronous clear before the next edge
        cycle("rst_a", 1'b1, 1'b0, 1'b0, {5'd3, 5'd9}, 2'b11, 64'hdead_beef_1234_5678);
        cycle("rst_b", 1'b0, 1'b0, 1'b0, '0, '0, '0);
        #2 rst_i = 1'b0;
        #1;
        check("async rst valid", wb_valid_o, 0);
        check("async rst wreg",  wb_wreg_o,  0);
        check("async rst wd",    wb_wd_o,    0);
        check("async rst wdata", wb_wdata_o, 0);
        q.delete();
        m_zero = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("rst release ready", mem_ready_o, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] wd;
            for (int k = 0; k < LANES; k++) wd[k*ADDR_W +: ADDR_W] = 5'($urandom_range(0, 3));
            cycle("rand", ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 20) == 0,
                  wd, LANES'($urandom), {$urandom, $urandom});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
